// File: rtl/jt12_wrqueue.sv
// jt12_wrqueue: host-side write queue feeding the YM clock-domain synchroniser.
// Buffers host register writes in a FIFO and replays them one at a time,
// waiting for a full rise and fall of the synchroniser busy bit between writes.
//
// Ports:
//   clk, rst                  host clock, asynchronous active-high reset
//   host_wr/addr/din          one-cycle write request with YM port address/data
//   flush                     discard all queued (not yet popped) entries
//   ovf_clr                   clears the sticky ovf and lost flags
//   host_full/empty/count     FIFO status (empty also requires an idle engine)
//   ovf                       sticky: a host write was dropped while full
//   lost                      sticky: busy never rose after a strobe
//   ym_cs_n/wr_n/addr/din     registered write interface to the synchroniser
//   ym_busy                   synchroniser busy status
//
// Optional feature: define JT12_WRQ_COALESCE_EN to merge consecutive data-port
// writes (odd addresses) to the same port into the not-yet-popped tail entry.
module jt12_wrqueue #(
  parameter int unsigned AW  = 4,
  parameter int unsigned TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_din,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic        host_full,
  output logic        host_empty,
  output logic [AW:0] host_count,
  output logic        ovf,
  output logic        lost,
  output logic        ym_cs_n,
  output logic        ym_wr_n,
  output logic [1:0]  ym_addr,
  output logic [7:0]  ym_din,
  input  logic        ym_busy
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    TMO_C   = 4'(TMO);

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] din;
  } wr_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAITSET, WAITCLR} state_t;

  state_t        state, state_nx;
  wr_entry_t     mem [DEPTH];
  wr_entry_t     head;
  logic [AW-1:0] wptr, rptr, tail_ptr;
  logic [CW-1:0] count;
  logic [3:0]    tmo_cnt, tmo_nx;
  logic          pop, push, drop, coal, set_lost;

  assign head     = mem[rptr];
  assign tail_ptr = wptr - AW'(1);

  // Pop only from an idle engine; a flush in the same cycle wins over the pop.
  assign pop = (state == IDLE) && (count != '0) && !flush;

`ifdef JT12_WRQ_COALESCE_EN
  logic [1:0] tail_addr;
  assign tail_addr = mem[tail_ptr].addr;
  // The tail must still be queued after this cycle, so a pop of the last entry blocks merging.
  assign coal = host_wr && !flush && host_addr[0] && (count != '0) &&
                !(pop && (count == CW'(1))) && (tail_addr == host_addr);
`else
  assign coal = 1'b0;
`endif

  assign push = host_wr && !flush && !coal && ((count != DEPTH_C) || pop);
  assign drop = host_wr && !flush && !coal && (count == DEPTH_C) && !pop;

  // FIFO storage (not reset; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{addr: host_addr, din: host_din};
    end else if (coal) begin
      mem[tail_ptr].din <= host_din;
    end
  end

  // Pointers, occupancy and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      lost  <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (set_lost)     lost <= 1'b1;
      else if (ovf_clr) lost <= 1'b0;
    end
  end

  // Handshake engine: next state and timeout counter
  always_comb begin
    state_nx = state;
    tmo_nx   = tmo_cnt;
    set_lost = 1'b0;
    case (state)
      IDLE: begin
        if (pop) state_nx = ISSUE;
      end
      ISSUE: begin
        tmo_nx   = TMO_C;
        state_nx = WAITSET;
      end
      WAITSET: begin
        if (ym_busy) begin
          state_nx = WAITCLR;
        end else if (tmo_cnt <= 4'd1) begin
          tmo_nx   = '0;
          set_lost = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo_cnt - 4'd1;
        end
      end
      WAITCLR: begin
        if (!ym_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strobes registered from the next state so they are low exactly while in ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      ym_cs_n <= 1'b1;
      ym_wr_n <= 1'b1;
      ym_addr <= '0;
      ym_din  <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_nx;
      ym_cs_n <= (state_nx != ISSUE);
      ym_wr_n <= (state_nx != ISSUE);
      if (pop) begin
        ym_addr <= head.addr;
        ym_din  <= head.din;
      end
    end
  end

  assign host_count = count;
  assign host_full  = (count == DEPTH_C);
  assign host_empty = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_jt12_wrqueue.sv
`timescale 1ns/1ps
module tb_jt12_wrqueue;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr, flush, ovf_clr;
  logic [1:0]  host_addr;
  logic [7:0]  host_din;
  logic        host_full, host_empty, ovf, lost;
  logic [AW:0] host_count;
  logic        ym_cs_n, ym_wr_n;
  logic [1:0]  ym_addr;
  logic [7:0]  ym_din;
  logic        ym_busy = 1'b0;

  jt12_wrqueue #(.AW(AW), .TMO(15)) dut (
    .clk(clk), .rst(rst),
    .host_wr(host_wr), .host_addr(host_addr), .host_din(host_din),
    .flush(flush), .ovf_clr(ovf_clr),
    .host_full(host_full), .host_empty(host_empty), .host_count(host_count),
    .ovf(ovf), .lost(lost),
    .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n), .ym_addr(ym_addr), .ym_din(ym_din),
    .ym_busy(ym_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Synchroniser model: 0 = responds to strobes, 1 = busy forced high, 2 = forced low
  int busy_mode = 0;
  int rnd_cfg   = 0;
  int rise_cnt  = 0;
  int hold_cnt  = 0;
  logic busy_auto = 1'b0;
  logic [9:0] strobes [$];
  int strobe_pair_err = 0;

  always @(negedge clk) begin
    if (ym_cs_n !== ym_wr_n) strobe_pair_err++;
    if (ym_cs_n === 1'b0 && ym_wr_n === 1'b0) begin
      strobes.push_back({ym_addr, ym_din});
      rise_cnt = (rnd_cfg != 0) ? int'($urandom_range(1, 3)) : 2;
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        busy_auto = 1'b1;
        hold_cnt  = (rnd_cfg != 0) ? int'($urandom_range(1, 5)) : 6;
      end
    end else if (busy_auto) begin
      hold_cnt--;
      if (hold_cnt <= 0) busy_auto = 1'b0;
    end
    ym_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : busy_auto;
  end

  // Reference: every write expected to reach the synchroniser, in order
  logic [9:0] exp_q [$];
  logic [9:0] pend  [$];
  int sidx = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    host_wr = 1'b1; host_addr = a; host_din = d;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic wait_strobe(int n, string tag);
    int t = 0;
    while (strobes.size() < n && t < 200) begin tick(); t++; end
    chk(tag, 32'(t < 200), 1);
  endtask

  // Queue a write into the stalled-engine model (engine busy, no pops)
  task automatic model_push(logic [1:0] a, logic [7:0] d, inout int dropped);
    logic [9:0] tl;
    bit merged = 0;
`ifdef JT12_WRQ_COALESCE_EN
    if (pend.size() > 0 && a[0]) begin
      tl = pend[pend.size()-1];
      if (tl[9:8] == a) begin
        tl[7:0] = d;
        pend[pend.size()-1] = tl;
        merged = 1;
      end
    end
`endif
    if (!merged) begin
      if (pend.size() < DEPTH) pend.push_back({a, d});
      else dropped++;
    end
  endtask

  task automatic flush_pend();
    foreach (pend[i]) exp_q.push_back(pend[i]);
    pend.delete();
  endtask

  task automatic prime(logic [1:0] a, logic [7:0] d, string tag);
    busy_mode = 1;
    wr(a, d);
    exp_q.push_back({a, d});
    wait_strobe(exp_q.size(), tag);
  endtask

  task automatic drain(string tag);
    int t = 0;
    busy_mode = 0;
    rnd_cfg   = 1;
    while ((strobes.size() < exp_q.size() || !host_empty) && t < 3000) begin tick(); t++; end
    chk({tag, "_timeout"}, 32'(t < 3000), 1);
    repeat (20) tick();
    chk({tag, "_total"}, strobes.size(), exp_q.size());
    for (int i = sidx; i < exp_q.size() && i < strobes.size(); i++)
      chk($sformatf("%s_order%0d", tag, i), 32'(strobes[i]), 32'(exp_q[i]));
    sidx = strobes.size();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dropped, k, maxc;
    logic [1:0] a;
    logic [7:0] d;

    rst = 1'b0; host_wr = 1'b0; host_addr = '0; host_din = '0;
    flush = 1'b0; ovf_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_empty", host_empty, 1);
    chk("rst_full", host_full, 0);
    chk("rst_count", host_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_lost", lost, 0);
    chk("rst_cs_n", ym_cs_n, 1);
    chk("rst_wr_n", ym_wr_n, 1);
    chk("rst_addr", ym_addr, 0);
    chk("rst_din", ym_din, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single write with busy rising 2 cycles after the strobe and falling 6 later
    busy_mode = 0; rnd_cfg = 0;
    wr(2'd0, 8'h2A);
    exp_q.push_back({2'd0, 8'h2A});
    wait_strobe(1, "t1_strobe_seen");
    chk("t1_strobe", 32'(strobes[0]), 32'({2'd0, 8'h2A}));
    t = 0;
    while (!ym_busy && t < 50) begin tick(); t++; end
    while (ym_busy && t < 50) begin tick(); t++; end
    chk("t1_busy_cycle", 32'(t < 50), 1);
    chk("t1_empty_at_fall", host_empty, 0);
    tick();
    chk("t1_empty_after", host_empty, 1);
    repeat (10) tick();
    chk("t1_one_strobe", strobes.size(), 1);
    sidx = 1;

    // Fill to full while the engine is stalled in WAITCLR, then overflow
    prime(2'd2, 8'h55, "t2_prime");
    dropped = 0;
    for (int i = 0; i < 16; i++) begin
      a = 2'(i); d = 8'($urandom);
      wr(a, d);
      model_push(a, d, dropped);
    end
    chk("t2_full", host_full, 1);
    chk("t2_count16", host_count, 16);
    chk("t2_ovf_before", ovf, 0);
    chk("t2_not_empty", host_empty, 0);
    wr(2'd0, 8'hEE);
    chk("t2_ovf_set", ovf, 1);
    chk("t2_count_held", host_count, 16);
    ovf_clr = 1'b1; host_wr = 1'b1; host_addr = 2'd1; host_din = 8'hDD;
    tick();
    ovf_clr = 1'b0; host_wr = 1'b0;
    chk("t2_set_wins", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t2_ovf_clr", ovf, 0);
    flush_pend();
    drain("t2");

    // Random bursts against a stalled engine
    for (int r = 0; r < 3; r++) begin
      prime(2'd0, 8'($urandom), "rb_prime");
      dropped = 0;
      k = int'($urandom_range(5, 20));
      for (int i = 0; i < k; i++) begin
        a = 2'($urandom); d = 8'($urandom);
        wr(a, d);
        model_push(a, d, dropped);
      end
      chk($sformatf("rb%0d_count", r), host_count, pend.size());
      chk($sformatf("rb%0d_ovf", r), ovf, 32'(dropped > 0));
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      flush_pend();
      drain($sformatf("rb%0d", r));
    end

    // Interleaved pushes and pops, wrapping the pointers several times
    busy_mode = 0; rnd_cfg = 1; maxc = 0;
    for (int n = 0; n < 40; n++) begin
      repeat (int'($urandom_range(0, 3))) begin
        tick();
        if (int'(host_count) > maxc) maxc = int'(host_count);
      end
      t = 0;
      while ((exp_q.size() - strobes.size()) > 12 && t < 500) begin tick(); t++; end
`ifdef JT12_WRQ_COALESCE_EN
      a = {1'($urandom), 1'b0};
`else
      a = 2'($urandom);
`endif
      d = 8'($urandom);
      wr(a, d);
      exp_q.push_back({a, d});
      if (int'(host_count) > maxc) maxc = int'(host_count);
    end
    chk("il_max_count", 32'(maxc <= 16), 1);
    chk("il_no_ovf", ovf, 0);
    drain("il");

    // Busy never rises: lost after 15 cycles in WAITSET
    busy_mode = 2;
    wr(2'd1, 8'h77);
    exp_q.push_back({2'd1, 8'h77});
    wait_strobe(exp_q.size(), "lost_strobe");
    repeat (15) tick();
    chk("lost_not_yet", lost, 0);
    tick();
    chk("lost_set", lost, 1);
    chk("lost_idle", host_empty, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("lost_clr", lost, 0);
    sidx = strobes.size();

    // Flush during WAITCLR with 5 entries queued
    prime(2'd3, 8'h99, "fl_prime");
    for (int i = 0; i < 5; i++) wr(2'(i), 8'($urandom));
    chk("fl_count5", host_count, 5);
    flush = 1'b1; host_wr = 1'b1; host_addr = 2'd2; host_din = 8'h44;
    tick();
    flush = 1'b0; host_wr = 1'b0;
    chk("fl_count0", host_count, 0);
    chk("fl_no_ovf", ovf, 0);
    chk("fl_inflight", host_empty, 0);
    busy_mode = 0;
    repeat (40) tick();
    chk("fl_strobes", strobes.size(), exp_q.size());
    chk("fl_empty", host_empty, 1);
    sidx = strobes.size();

    // Reset in the middle of a handshake
    busy_mode = 1;
    wr(2'd0, 8'h11);
    exp_q.push_back({2'd0, 8'h11});
    wr(2'd2, 8'h22);
    wait_strobe(exp_q.size(), "mr_strobe");
    rst = 1'b1;
    #1;
    chk("mr_cs_n", ym_cs_n, 1);
    chk("mr_wr_n", ym_wr_n, 1);
    chk("mr_count", host_count, 0);
    chk("mr_din", ym_din, 0);
    tick();
    rst = 1'b0;
    busy_mode = 0;
    repeat (40) tick();
    chk("mr_no_replay", strobes.size(), exp_q.size());
    chk("mr_empty", host_empty, 1);
    sidx = strobes.size();

`ifdef JT12_WRQ_COALESCE_EN
    prime(2'd2, 8'h01, "co_prime");
    wr(2'd1, 8'h10);
    wr(2'd1, 8'h20);
    chk("co_merge_count", host_count, 1);
    wr(2'd0, 8'h30);
    wr(2'd0, 8'h31);
    chk("co_even_count", host_count, 3);
    chk("co_no_ovf", ovf, 0);
    exp_q.push_back({2'd1, 8'h20});
    exp_q.push_back({2'd0, 8'h30});
    exp_q.push_back({2'd0, 8'h31});
    drain("co");
`endif

    chk("strobe_pair", strobe_pair_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
